// File: rtl/csr_bank.sv
// Machine-mode CSR bank: trap/return sequencing, WARL masking, interrupt pending and 64-bit counters.
// Read data, legality and trap target are combinational views of the registered state.
module csr_bank #(
    parameter int unsigned XLEN         = 32,
    parameter logic [63:0] HART_ID      = 64'd0,
    parameter logic [63:0] MTVEC_RESET  = 64'd0,
    parameter int unsigned HAS_COUNTERS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_ra,
    output logic [XLEN-1:0] csr_rd,
    input  logic            csr_we,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_wa,
    input  logic [XLEN-1:0] csr_wd,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_req,
    input  logic            retire,
    input  logic            irq_sw,
    input  logic            irq_timer,
    input  logic            irq_ext,
    output logic            irq_pending,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_out,
    output logic            illegal_access
);

    localparam logic [11:0] A_MSTATUS  = 12'h300, A_MISA     = 12'h301, A_MIE      = 12'h304,
                            A_MTVEC    = 12'h305, A_MSCRATCH = 12'h340, A_MEPC     = 12'h341,
                            A_MCAUSE   = 12'h342, A_MIP      = 12'h344, A_MHARTID  = 12'hF14,
                            A_MCYCLE   = 12'hB00, A_MCYCLEH  = 12'hB80, A_MINSTRET = 12'hB02,
                            A_MINSTRETH= 12'hB82, A_CYCLE    = 12'hC00, A_CYCLEH   = 12'hC80,
                            A_INSTRET  = 12'hC02, A_INSTRETH = 12'hC82;
    localparam bit X32 = (XLEN == 32);
    localparam bit CNT = (HAS_COUNTERS != 0);
    localparam logic [XLEN-1:0] MISA_VAL =
        {(X32 ? 2'b01 : 2'b10), {(XLEN-2){1'b0}}} | XLEN'(32'h100);

    logic            st_mie, st_mpie;
    logic [2:0]      mie_bits, mip_bits;    // {11, 7, 3}
    logic [XLEN-1:0] mtvec_r, mscratch_r, mepc_r, mcause_r;
    logic [63:0]     mcycle, minstret;
    logic [XLEN-1:0] old_val, wval;
    logic            sw_wr;

    function automatic logic csr_legal(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MISA, A_MIE, A_MTVEC, A_MSCRATCH,
            A_MEPC, A_MCAUSE, A_MIP, A_MHARTID:           csr_legal = 1'b1;
            A_MCYCLE, A_MINSTRET, A_CYCLE, A_INSTRET:     csr_legal = CNT;
            A_MCYCLEH, A_MINSTRETH, A_CYCLEH, A_INSTRETH: csr_legal = CNT && X32;
            default:                                      csr_legal = 1'b0;
        endcase
    endfunction

    function automatic logic csr_ro(input logic [11:0] a);
        case (a)
            A_MISA, A_MIP, A_MHARTID, A_CYCLE, A_CYCLEH, A_INSTRET, A_INSTRETH: csr_ro = 1'b1;
            default:                                                            csr_ro = 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] irq_word(input logic [2:0] b);
        logic [XLEN-1:0] v;
        v     = '0;
        v[11] = b[2];
        v[7]  = b[1];
        v[3]  = b[0];
        return v;
    endfunction

    function automatic logic [XLEN-1:0] csr_value(input logic [11:0] a);
        case (a)
            A_MSTATUS:              csr_value = XLEN'({2'b11, 3'b000, st_mpie, 3'b000, st_mie, 3'b000});
            A_MISA:                 csr_value = MISA_VAL;
            A_MIE:                  csr_value = irq_word(mie_bits);
            A_MTVEC:                csr_value = mtvec_r;
            A_MSCRATCH:             csr_value = mscratch_r;
            A_MEPC:                 csr_value = mepc_r;
            A_MCAUSE:               csr_value = mcause_r;
            A_MIP:                  csr_value = irq_word(mip_bits);
            A_MHARTID:              csr_value = XLEN'(HART_ID);
            A_MCYCLE, A_CYCLE:      csr_value = XLEN'(mcycle);
            A_MCYCLEH, A_CYCLEH:    csr_value = XLEN'(mcycle[63:32]);
            A_MINSTRET, A_INSTRET:  csr_value = XLEN'(minstret);
            A_MINSTRETH, A_INSTRETH: csr_value = XLEN'(minstret[63:32]);
            default:                csr_value = '0;
        endcase
    endfunction

    always_comb begin
        old_val = csr_value(csr_wa);
        case (csr_op)
            2'b01:   wval = csr_wd;
            2'b10:   wval = old_val | csr_wd;
            2'b11:   wval = old_val & ~csr_wd;
            default: wval = old_val;
        endcase
        // Traps and returns own the cycle; a coincident software write is dropped.
        sw_wr = csr_we && (csr_op != 2'b00) && csr_legal(csr_wa) && !csr_ro(csr_wa)
                && !trap_req && !mret_req;
        illegal_access = !csr_legal(csr_ra) ||
                         (csr_we && (csr_op != 2'b00) && (!csr_legal(csr_wa) || csr_ro(csr_wa)));
        csr_rd      = csr_value(csr_ra);
        irq_pending = st_mie && |(mip_bits & mie_bits);
        mepc_out    = mepc_r;
        trap_vector = {mtvec_r[XLEN-1:2], 2'b00};
        if (mtvec_r[0] && trap_cause[XLEN-1])
            trap_vector = {mtvec_r[XLEN-1:2], 2'b00} + XLEN'({trap_cause[5:0], 2'b00});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_bits   <= '0;
            mip_bits   <= '0;
            mtvec_r    <= XLEN'(MTVEC_RESET) & ~XLEN'(2);
            mscratch_r <= '0;
            mepc_r     <= '0;
            mcause_r   <= '0;
            mcycle     <= '0;
            minstret   <= '0;
        end else begin
            mip_bits <= {irq_ext, irq_timer, irq_sw};
            mcycle   <= mcycle + 64'd1;
            if (retire)
                minstret <= minstret + 64'd1;
            if (trap_req) begin
                mepc_r   <= trap_pc & ~XLEN'(3);
                mcause_r <= trap_cause;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else if (mret_req) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (sw_wr) begin
                // Counter writes come last so they override this cycle's increment.
                case (csr_wa)
                    A_MSTATUS: begin
                        st_mie  <= wval[3];
                        st_mpie <= wval[7];
                    end
                    A_MIE:       mie_bits   <= {wval[11], wval[7], wval[3]};
                    A_MTVEC:     mtvec_r    <= wval & ~XLEN'(2);
                    A_MSCRATCH:  mscratch_r <= wval;
                    A_MEPC:      mepc_r     <= wval & ~XLEN'(3);
                    A_MCAUSE:    mcause_r   <= wval;
                    A_MCYCLE:    mcycle     <= X32 ? {mcycle[63:32], wval[31:0]} : 64'(wval);
                    A_MCYCLEH:   mcycle     <= {wval[31:0], mcycle[31:0]};
                    A_MINSTRET:  minstret   <= X32 ? {minstret[63:32], wval[31:0]} : 64'(wval);
                    A_MINSTRETH: minstret   <= {wval[31:0], minstret[31:0]};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_bank.sv
// Scoreboard bench for csr_bank (XLEN=32): expected read values are queued with each read
// address and compared once the combinational read settles.
module tb_csr_bank;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_ra, csr_wa;
    logic [31:0] csr_rd, csr_wd, trap_cause, trap_pc, trap_vector, mepc_out;
    logic        csr_we, trap_req, mret_req, retire;
    logic [1:0]  csr_op;
    logic        irq_sw, irq_timer, irq_ext, irq_pending, illegal_access;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];
    logic [11:0] ra_q[$];
    logic [31:0] exp_v;

    csr_bank #(.XLEN(32), .HART_ID(64'd5), .MTVEC_RESET(64'h200), .HAS_COUNTERS(1)) dut (
        .clk(clk), .rst(rst), .csr_ra(csr_ra), .csr_rd(csr_rd), .csr_we(csr_we),
        .csr_op(csr_op), .csr_wa(csr_wa), .csr_wd(csr_wd), .trap_req(trap_req),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .mret_req(mret_req), .retire(retire),
        .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext), .irq_pending(irq_pending),
        .trap_vector(trap_vector), .mepc_out(mepc_out), .illegal_access(illegal_access)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_we = 1'b1; csr_wa = a; csr_op = op; csr_wd = d;
        tick();
        csr_we = 1'b0; csr_op = 2'b00;
    endtask

    task automatic expect_rd(input logic [11:0] a, input logic [31:0] e);
        ra_q.push_back(a);
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        expect_rd(12'h300, 32'h1800); expect_rd(12'h301, 32'h4000_0100);
        expect_rd(12'h304, 32'h0);    expect_rd(12'h305, 32'h200);
        expect_rd(12'h340, 32'h0);    expect_rd(12'h341, 32'h0);
        expect_rd(12'h342, 32'h0);    expect_rd(12'h344, 32'h0);
        expect_rd(12'hF14, 32'h5);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL reset_rd addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
        checks++;
        if (irq_pending !== 1'b0 || illegal_access !== 1'b0 || mepc_out !== 32'h0) begin
            failures++; $display("FAIL reset_out pend=%b ill=%b mepc=%h exp 0/0/0", irq_pending, illegal_access, mepc_out);
        end
    endtask

    task automatic test_warl();
        wr(12'h300, 2'b01, 32'hFFFF_FFFF); wr(12'h304, 2'b01, 32'hFFFF_FFFF);
        wr(12'h305, 2'b01, 32'hFFFF_FFFF); wr(12'h341, 2'b01, 32'hFFFF_FFFF);
        wr(12'h340, 2'b01, 32'h0000_F0F0); wr(12'h340, 2'b10, 32'h0000_000F);
        expect_rd(12'h300, 32'h1888);      expect_rd(12'h304, 32'h888);
        expect_rd(12'h305, 32'hFFFF_FFFD); expect_rd(12'h341, 32'hFFFF_FFFC);
        expect_rd(12'h340, 32'h0000_F0FF);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL warl_rd addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
        wr(12'h340, 2'b11, 32'h0000_00F0);
        wr(12'h300, 2'b01, 32'h0);
        wr(12'h304, 2'b01, 32'h0);
        expect_rd(12'h340, 32'h0000_F00F); expect_rd(12'h300, 32'h1800); expect_rd(12'h304, 32'h0);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL setclr_rd addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
    endtask

    task automatic test_trap();
        wr(12'h300, 2'b01, 32'h8);
        trap_req = 1'b1; trap_pc = 32'h1002; trap_cause = 32'h8000_0007;
        tick();
        trap_req = 1'b0;
        checks++;
        if (mepc_out !== 32'h1000) begin failures++; $display("FAIL trap_mepc_out got=%h exp=%h", mepc_out, 32'h1000); end
        expect_rd(12'h341, 32'h1000); expect_rd(12'h342, 32'h8000_0007); expect_rd(12'h300, 32'h1880);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL trap_rd addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
        mret_req = 1'b1;
        tick();
        mret_req = 1'b0;
        expect_rd(12'h300, 32'h1888);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL mret_rd addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
    endtask

    task automatic test_vector();
        wr(12'h305, 2'b01, 32'h101);
        trap_cause = 32'h8000_0007; #1; checks++;
        if (trap_vector !== 32'h11C) begin failures++; $display("FAIL vec_irq got=%h exp=%h", trap_vector, 32'h11C); end
        trap_cause = 32'h2; #1; checks++;
        if (trap_vector !== 32'h100) begin failures++; $display("FAIL vec_exc got=%h exp=%h", trap_vector, 32'h100); end
        wr(12'h305, 2'b01, 32'h100);
        trap_cause = 32'h8000_0007; #1; checks++;
        if (trap_vector !== 32'h100) begin failures++; $display("FAIL vec_direct got=%h exp=%h", trap_vector, 32'h100); end
        trap_cause = 32'h0;
    endtask

    task automatic test_counters();
        wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
        wr(12'hB80, 2'b01, 32'h0);
        tick();
        expect_rd(12'hB00, 32'h0); expect_rd(12'hB80, 32'h1); expect_rd(12'hC80, 32'h1);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL mcycle_rd addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
        wr(12'hB02, 2'b01, 32'h5);
        retire = 1'b1;
        repeat (3) tick();
        retire = 1'b0;
        expect_rd(12'hB02, 32'h8); expect_rd(12'hC02, 32'h8); expect_rd(12'hB82, 32'h0);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL minstret_rd addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
        retire = 1'b1;
        wr(12'hB02, 2'b01, 32'hA);
        retire = 1'b0;
        expect_rd(12'hB02, 32'hA);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL minstret_supp addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
    endtask

    task automatic test_priority();
        wr(12'h340, 2'b01, 32'h1234);
        wr(12'h300, 2'b01, 32'h8);
        trap_req = 1'b1; trap_pc = 32'h2000; trap_cause = 32'hB; mret_req = 1'b1;
        csr_we = 1'b1; csr_wa = 12'h340; csr_op = 2'b01; csr_wd = 32'hDEAD;
        tick();
        trap_req = 1'b0; mret_req = 1'b0; csr_we = 1'b0; csr_op = 2'b00;
        expect_rd(12'h340, 32'h1234); expect_rd(12'h341, 32'h2000);
        expect_rd(12'h342, 32'hB);    expect_rd(12'h300, 32'h1880);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL prio_trap addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
        mret_req = 1'b1;
        csr_we = 1'b1; csr_wa = 12'h340; csr_op = 2'b01; csr_wd = 32'hBEEF;
        tick();
        mret_req = 1'b0; csr_we = 1'b0; csr_op = 2'b00;
        expect_rd(12'h340, 32'h1234); expect_rd(12'h300, 32'h1888);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL prio_mret addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
    endtask

    task automatic test_illegal();
        csr_ra = 12'hF14; csr_we = 1'b1; csr_wa = 12'hF14; csr_op = 2'b01; csr_wd = 32'h0;
        #1; checks++;
        if (illegal_access !== 1'b1) begin failures++; $display("FAIL ill_hartid_wr got=%b exp=1", illegal_access); end
        tick();
        csr_op = 2'b00; #1; checks++;
        if (illegal_access !== 1'b0) begin failures++; $display("FAIL ill_op00 got=%b exp=0", illegal_access); end
        csr_we = 1'b0; csr_ra = 12'h123; #1; checks++;
        if (illegal_access !== 1'b1) begin failures++; $display("FAIL ill_unmapped_rd got=%b exp=1", illegal_access); end
        csr_ra = 12'h300; csr_we = 1'b1; csr_wa = 12'hC00; csr_op = 2'b10; #1; checks++;
        if (illegal_access !== 1'b1) begin failures++; $display("FAIL ill_cycle_wr got=%b exp=1", illegal_access); end
        csr_we = 1'b0;
        wr(12'h344, 2'b01, 32'hFFFF_FFFF);
        wr(12'h301, 2'b01, 32'h0);
        expect_rd(12'hF14, 32'h5); expect_rd(12'h344, 32'h0); expect_rd(12'h301, 32'h4000_0100);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL ill_rd addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
    endtask

    task automatic test_irq();
        wr(12'h304, 2'b01, 32'h80);
        wr(12'h300, 2'b01, 32'h8);
        irq_timer = 1'b1; #1; checks++;
        if (irq_pending !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq_pending); end
        tick(); tick(); checks++;
        if (irq_pending !== 1'b1) begin failures++; $display("FAIL irq_pending got=%b exp=1", irq_pending); end
        expect_rd(12'h344, 32'h80);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL irq_mip addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
        wr(12'h300, 2'b11, 32'h8);
        #1; checks++;
        if (irq_pending !== 1'b0) begin failures++; $display("FAIL irq_masked got=%b exp=0", irq_pending); end
        irq_timer = 1'b0;
        irq_sw = 1'b1;
        wr(12'h300, 2'b10, 32'h8);
        tick(); checks++;
        if (irq_pending !== 1'b0) begin failures++; $display("FAIL irq_sw_disabled got=%b exp=0", irq_pending); end
        irq_sw = 1'b0;
    endtask

    task automatic test_back_to_back();
        csr_ra = 12'h340; csr_we = 1'b1; csr_wa = 12'h340; csr_op = 2'b01; csr_wd = 32'h55;
        sb_q.push_back(32'h1234);
        #1; exp_v = sb_q.pop_front(); checks++;
        if (csr_rd !== exp_v) begin failures++; $display("FAIL nobypass got=%h exp=%h", csr_rd, exp_v); end
        tick();
        csr_we = 1'b0; csr_op = 2'b00;
        wr(12'h340, 2'b01, 32'h1);
        wr(12'h340, 2'b10, 32'h2);
        wr(12'h340, 2'b11, 32'h1);
        expect_rd(12'h340, 32'h2);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL b2b_rd addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
    endtask

    task automatic test_reset_priority();
        trap_req = 1'b1; trap_pc = 32'h3000; trap_cause = 32'h5; rst = 1'b1;
        csr_we = 1'b1; csr_wa = 12'h340; csr_op = 2'b01; csr_wd = 32'hAAAA;
        tick();
        trap_req = 1'b0; csr_we = 1'b0; csr_op = 2'b00; rst = 1'b0;
        expect_rd(12'hB00, 32'h0);   expect_rd(12'h341, 32'h0); expect_rd(12'h342, 32'h0);
        expect_rd(12'h340, 32'h0);   expect_rd(12'h305, 32'h200); expect_rd(12'h300, 32'h1800);
        while (ra_q.size() > 0) begin
            csr_ra = ra_q.pop_front(); #1; exp_v = sb_q.pop_front(); checks++;
            if (csr_rd !== exp_v) begin failures++; $display("FAIL rstprio_rd addr=%h got=%h exp=%h", csr_ra, csr_rd, exp_v); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; csr_ra = 12'h300; csr_wa = 12'h0; csr_wd = '0; csr_we = 1'b0; csr_op = 2'b00;
        trap_req = 1'b0; trap_cause = '0; trap_pc = '0; mret_req = 1'b0; retire = 1'b0;
        irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        test_reset();
        test_warl();
        test_trap();
        test_vector();
        test_counters();
        test_priority();
        test_illegal();
        test_irq();
        test_back_to_back();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csr_bank.md
CSR_BANK -- requirements
Module: csr_bank

Interface
REQ-001 Parameter: XLEN, 32, data width; 32 or 64 only.
REQ-002 Parameter: HART_ID, 0, value returned by mhartid.
REQ-003 Parameter: MTVEC_RESET, 0, mtvec value after reset.
REQ-004 Parameter: HAS_COUNTERS, 1, 1 implements mcycle/minstret; 0 makes those addresses illegal.
REQ-005 One clock, clk; reset is rst, synchronous, active-high.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 csr_ra  in  12  read address.
REQ-009 csr_rd  out  XLEN  read data, combinational from registered state.
REQ-010 csr_we  in  1  software write strobe.
REQ-011 csr_op  in  2  01 write, 10 set, 11 clear; 00 no write.
REQ-012 csr_wa  in  12  write address.
REQ-013 csr_wd  in  XLEN  write operand.
REQ-014 trap_req  in  1  trap entry this cycle.
REQ-015 trap_cause, trap_pc  in  XLEN each  cause value and faulting PC.
REQ-016 mret_req  in  1  return from trap.
REQ-017 retire  in  1  one instruction retired this cycle.
REQ-018 irq_sw, irq_timer, irq_ext  in  1 each  raw interrupt lines.
REQ-019 irq_pending  out  1  enabled interrupt pending.
REQ-020 trap_vector, mepc_out  out  XLEN each  trap target; current mepc.
REQ-021 illegal_access  out  1  current read or write access is illegal.

Function
REQ-022 Map: mstatus 0x300, misa 0x301 (RO), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (RO), mcycle 0xB00/0xB80, minstret 0xB02/0xB82, cycle 0xC00/0xC80 (RO), instret 0xC02/0xC82 (RO), mhartid 0xF14 (RO).
REQ-023 The high-half addresses 0xB80/0xB82/0xC80/0xC82 are legal only when XLEN=32; when XLEN=64, the low-half addresses return the full 64-bit counter.
REQ-024 Write value: op 01 -> wd; 10 -> old|wd; 11 -> old&~wd.
REQ-025 WARL masks: mstatus writable bits 3 (MIE), 7 (MPIE); MPP[12:11] reads 11; mie writable bits 3, 7, 11; mepc[1:0] and mtvec[1] read 0.
REQ-026 illegal_access is asserted when csr_ra is unmapped, or when csr_we is high with op != 00 and csr_wa is unmapped or RO; an illegal write changes no state.
REQ-027 mip bits 3/7/11 are irq_sw/irq_timer/irq_ext registered once; software writes to mip are ignored.
REQ-028 irq_pending = mstatus.MIE & |(mip & mie), computed combinationally from registered state.
REQ-029 Trap entry (trap_req): mepc<=trap_pc&~3; mcause<=trap_cause; MPIE<=MIE; MIE<=0; all updates occur in one cycle.
REQ-030 mret_req: MIE<=MPIE; MPIE<=1.
REQ-031 Priority in a single cycle: trap_req > mret_req > csr_we; a lower-priority request is dropped, not queued.
REQ-032 trap_vector = mtvec base when mtvec[0]=0 or trap_cause MSB=0; otherwise base + 4*trap_cause[5:0].
REQ-033 mcycle is 64-bit and increments every cycle; minstret is 64-bit and increments when retire=1; both wrap from all-ones to 0.
REQ-034 A software write to any counter half replaces that half in that cycle and suppresses that counter's increment in that cycle; the other half is held.
REQ-035 There is no read bypass: a read issued in the same cycle as a write to the same address returns the old value.
REQ-036 When not written, all state is held.

Reset
REQ-037 On rst, mtvec <= MTVEC_RESET; all other writable CSRs, mip and both counters <= 0; irq_pending = 0.
REQ-038 rst has priority over trap_req, mret_req and csr_we in the same cycle.
REQ-039 Reset asserted mid-trap discards the in-flight trap update.

Verification
REQ-040 Write mstatus=0xFFFFFFFF (op 01), then read -> 0x00001888.
REQ-041 mstatus.MIE=1, MPIE=0, trap_req with trap_pc=0x1002, cause=0x80000007 -> next cycle mepc=0x1000, mcause=0x80000007, MIE=0, MPIE=1.
REQ-042 mtvec=0x101, interrupt cause 7 -> trap_vector=0x11C; with cause 2 (exception) -> trap_vector=0x100.
REQ-043 XLEN=32, write mcycle=0xFFFFFFFF and mcycleh=0x0, then one idle cycle -> mcycle=0, mcycleh=1.
REQ-044 trap_req, mret_req and a csr_we to mscratch in the same cycle -> only the trap takes effect; mscratch unchanged.
REQ-045 Write to 0xF14 -> illegal_access=1 and mhartid still reads HART_ID; set mie=0x80, MIE=1, raise irq_timer -> irq_pending=1 two cycles later.
